control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Port clk  input  1  system clock; all state changes on the rising edge.
REQ-002 Port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 Port I_addr  output  16  instruction memory address; equals PC.
REQ-004 Port I_rd  output  1  instruction memory read enable.
REQ-005 Port I_data  input  16  instruction word; combinational read, valid in the same cycle as I_rd.
REQ-006 Port D_addr  output  8  data memory address.
REQ-007 Port D_rd / D_wr  output  1 each  data memory read / write enables; never both 1.
REQ-008 Port RF_s  output  1  write-data select to datapath (1 = DM_Din, 0 = ALU result).
REQ-009 Port RF_W_addr / RF_Rp_addr / RF_Rq_addr  output  4 each  register addresses.
REQ-010 Port RF_W_wr / RF_Rp_rd / RF_Rq_rd  output  1 each  register write / read enables.
REQ-011 Port alu_s0  output  1  ALU operation select (0 = add, 1 = subtract).
REQ-012 Port Val_cons  output  8  immediate constant to datapath.
REQ-013 Port RF_cons  output  1  select immediate as register write data.
REQ-014 Port RF_ext  output  1  two's-complement negate register write data.
REQ-015 Port RF_Rp_zero  input  1  datapath flag: 1 when Rp_data == 0.
REQ-016 Port halted  output  1  1 while in state HALT.

Function
REQ-017 Instruction format: opcode = IR[15:12], ra = IR[11:8], rb = IR[7:4], rc = IR[3:0], imm/d/off = IR[7:0].
REQ-018 Opcodes SHALL be: 0000 LOAD ra,d; 0001 STORE ra,d; 0010 ADD ra,rb,rc; 0011 LDC ra,imm; 0100 SUB ra,rb,rc; 0101 JMPZ ra,off; 0110 LDN ra,imm; 1111 HALT; all others execute as NOP.
REQ-019 FSM states SHALL be INIT, FETCH, DECODE, LOAD, STORE, ALU, LDC, LDN, JMPZ, JMPZ_JMP, HALT.
REQ-020 Every output not explicitly driven in a state SHALL be 0; I_addr = PC in all states.
REQ-021 INIT: PC <= 0, IR <= 0; next FETCH.
REQ-022 FETCH: I_rd = 1; IR <= I_data, PC <= PC + 1 (16-bit wrap, 0xFFFF -> 0x0000); next DECODE.
REQ-023 DECODE: no outputs asserted; next state by opcode (ADD/SUB -> ALU, undefined -> FETCH, HALT -> HALT).
REQ-024 LOAD: D_addr = d, D_rd = 1, RF_s = 1, RF_W_addr = ra, RF_W_wr = 1; next FETCH.
REQ-025 STORE: D_addr = d, D_wr = 1, RF_Rp_addr = ra, RF_Rp_rd = 1; next FETCH.
REQ-026 ALU: RF_Rp_addr = rb, RF_Rq_addr = rc, both read enables 1, alu_s0 = opcode[2], RF_s = 0, RF_W_addr = ra, RF_W_wr = 1; next FETCH; result width 16 bits, carry discarded.
REQ-027 LDC: Val_cons = imm, RF_cons = 1, RF_W_addr = ra, RF_W_wr = 1 (zero-extended); next FETCH.
REQ-028 LDN: as LDC plus RF_ext = 1 (writes -imm, 16-bit two's complement); next FETCH.
REQ-029 JMPZ: RF_Rp_addr = ra, RF_Rp_rd = 1; next JMPZ_JMP if RF_Rp_zero = 1, else FETCH.
REQ-030 JMPZ_JMP: PC <= PC + sign_extend(off) - 1 (target relative to the JMPZ address, 16-bit wrap); next FETCH.
REQ-031 HALT: halted = 1, no memory or register enables; remains in HALT until rst.
REQ-032 Latency: LOAD/STORE/ALU/LDC/LDN/not-taken JMPZ/NOP = 3 cycles; taken JMPZ = 4 cycles.
REQ-033 RF_W_addr, RF_Rp_addr and RF_Rq_addr SHALL be 0 in states where their enable is 0.

Reset
REQ-034 rst = 1 on any edge SHALL force state INIT, PC = 0, IR = 0, halted = 0, regardless of the current state, including mid-instruction and HALT.
REQ-035 While rst = 1, all outputs SHALL be 0 except I_addr = 0; an instruction interrupted by rst SHALL NOT complete its write.
REQ-036 After rst deasserts, the first FETCH SHALL occur one cycle after INIT, reading address 0.

Verification
REQ-037 ROM[0]=0x3105 (LDC R1,5), ROM[1]=0x6203 (LDN R2,3), ROM[2]=0x2312 (ADD R3,R1,R2) -> R3 = 0x0002 after cycle 10; RF_W_wr pulses once per instruction.
REQ-038 ROM[0]=0x4312 (SUB R3,R1,R2) with R1=2, R2=5 -> alu_s0=1 in ALU state, R3 = 0xFFFD.
REQ-039 ROM[0]=0x0410 (LOAD R4,0x10), ROM[1]=0x1420 (STORE R4,0x20), DM[0x10]=0xBEEF -> DM[0x20]=0xBEEF; D_rd and D_wr never high together.
REQ-040 JMPZ R5,0xFE at address 4 with R5=0 -> PC becomes 2 after JMPZ_JMP; with R5=1 -> PC = 5, no JMPZ_JMP state.
REQ-041 ROM[0]=0xF000 -> halted = 1 from cycle 3 on, I_rd stays 0; rst pulse -> halted = 0, fetch from address 0.
REQ-042 rst asserted during the ALU state of an ADD -> destination register unchanged, state INIT next cycle.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit register machine.
// All control outputs are decoded from the current state and IR only.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] I_addr,
  output logic        I_rd,
  input  logic [15:0] I_data,
  output logic [7:0]  D_addr,
  output logic        D_rd,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic [3:0]  RF_Rp_addr,
  output logic [3:0]  RF_Rq_addr,
  output logic        RF_W_wr,
  output logic        RF_Rp_rd,
  output logic        RF_Rq_rd,
  output logic        alu_s0,
  output logic [7:0]  Val_cons,
  output logic        RF_cons,
  output logic        RF_ext,
  input  logic        RF_Rp_zero,
  output logic        halted
);

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, LOAD, STORE, ALU, LDC, LDN, JMPZ, JMPZ_JMP, HALT
  } state_t;

  state_t      state, next_state;
  logic [15:0] pc, ir;
  logic [3:0]  opcode, ra, rb, rc;
  logic [7:0]  imm;

  assign opcode = ir[15:12];
  assign ra     = ir[11:8];
  assign rb     = ir[7:4];
  assign rc     = ir[3:0];
  assign imm    = ir[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= next_state;
      case (state)
        INIT: begin
          pc <= '0;
          ir <= '0;
        end
        FETCH: begin
          ir <= I_data;
          pc <= pc + 16'd1;
        end
        // PC already points past the JMPZ, so the -1 makes the offset JMPZ-relative
        JMPZ_JMP: pc <= pc + {{8{imm[7]}}, imm} - 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:   next_state = FETCH;
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (opcode)
          4'h0:       next_state = LOAD;
          4'h1:       next_state = STORE;
          4'h2, 4'h4: next_state = ALU;
          4'h3:       next_state = LDC;
          4'h5:       next_state = JMPZ;
          4'h6:       next_state = LDN;
          4'hF:       next_state = HALT;
          default:    next_state = FETCH;
        endcase
      end
      LOAD, STORE, ALU, LDC, LDN, JMPZ_JMP: next_state = FETCH;
      JMPZ:    next_state = RF_Rp_zero ? JMPZ_JMP : FETCH;
      HALT:    next_state = HALT;
      default: next_state = INIT;
    endcase
  end

  // rst masks every output in the same cycle, so an interrupted write never lands
  always_comb begin
    I_addr     = rst ? '0 : pc;
    I_rd       = 1'b0;
    D_addr     = '0;
    D_rd       = 1'b0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_Rp_addr = '0;
    RF_Rq_addr = '0;
    RF_W_wr    = 1'b0;
    RF_Rp_rd   = 1'b0;
    RF_Rq_rd   = 1'b0;
    alu_s0     = 1'b0;
    Val_cons   = '0;
    RF_cons    = 1'b0;
    RF_ext     = 1'b0;
    halted     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: I_rd = 1'b1;
        LOAD: begin
          D_addr    = imm;
          D_rd      = 1'b1;
          RF_s      = 1'b1;
          RF_W_addr = ra;
          RF_W_wr   = 1'b1;
        end
        STORE: begin
          D_addr     = imm;
          D_wr       = 1'b1;
          RF_Rp_addr = ra;
          RF_Rp_rd   = 1'b1;
        end
        ALU: begin
          RF_Rp_addr = rb;
          RF_Rq_addr = rc;
          RF_Rp_rd   = 1'b1;
          RF_Rq_rd   = 1'b1;
          alu_s0     = opcode[2];
          RF_W_addr  = ra;
          RF_W_wr    = 1'b1;
        end
        LDC, LDN: begin
          Val_cons  = imm;
          RF_cons   = 1'b1;
          RF_ext    = (state == LDN);
          RF_W_addr = ra;
          RF_W_wr   = 1'b1;
        end
        JMPZ: begin
          RF_Rp_addr = ra;
          RF_Rp_rd   = 1'b1;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: behavioural datapath/memories around the DUT plus an
// instruction-level reference model that predicts every cycle's outputs.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] I_addr, I_data;
  logic        I_rd;
  logic [7:0]  D_addr, Val_cons;
  logic        D_rd, D_wr, RF_s, RF_W_wr, RF_Rp_rd, RF_Rq_rd, alu_s0;
  logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic        RF_cons, RF_ext, RF_Rp_zero, halted;

  logic [15:0] rom    [65536];
  logic [15:0] env_rf [16];
  logic [15:0] env_dm [256];

  always #5 clk = ~clk;

  assign I_data     = rom[I_addr];
  assign RF_Rp_zero = (env_rf[RF_Rp_addr] == 16'h0000);

  control_unit dut (
    .clk(clk), .rst(rst), .I_addr(I_addr), .I_rd(I_rd), .I_data(I_data),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
    .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
    .alu_s0(alu_s0), .Val_cons(Val_cons), .RF_cons(RF_cons), .RF_ext(RF_ext),
    .RF_Rp_zero(RF_Rp_zero), .halted(halted)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int wr_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Datapath stand-in: register file, data memory and ALU driven by the DUT controls
  initial begin : env
    logic [15:0] a, b, wd;
    for (int i = 0; i < 16; i++) env_rf[i] = '0;
    for (int i = 0; i < 256; i++) env_dm[i] = 16'($urandom);
    env_dm[8'h10] = 16'hBEEF;
    env_dm[8'h20] = 16'h0000;
    forever begin
      @(posedge clk);
      a = env_rf[RF_Rp_addr];
      b = env_rf[RF_Rq_addr];
      if (RF_s)         wd = env_dm[D_addr];
      else if (RF_cons) wd = RF_ext ? 16'h0000 - {8'h00, Val_cons} : {8'h00, Val_cons};
      else              wd = alu_s0 ? a - b : a + b;
      if (D_wr)    env_dm[D_addr]    = a;
      if (RF_W_wr) env_rf[RF_W_addr] = wd;
    end
  end

  typedef struct packed {
    logic [15:0] i_addr;
    logic        i_rd;
    logic [7:0]  d_addr;
    logic        d_rd, d_wr, rf_s;
    logic [3:0]  w_addr, p_addr, q_addr;
    logic        w_wr, p_rd, q_rd, alu_s0;
    logic [7:0]  val_cons;
    logic        rf_cons, rf_ext, halted;
  } vec_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] addr;
    logic        last;
  } tag_t;

  vec_t        expq [$];
  tag_t        tagq [$];
  logic [15:0] m_rf [16];
  logic [15:0] m_dm [256];
  logic [15:0] m_pc   = '0;
  bit          m_halt = 1'b0;
  bit          m_init = 1'b0;

  function automatic vec_t base(input logic [15:0] ia);
    vec_t v = '0;
    v.i_addr = ia;
    return v;
  endfunction

  task automatic push(input vec_t v, input logic [15:0] ir, input logic [15:0] a, input logic last);
    tag_t t;
    t.ir = ir; t.addr = a; t.last = last;
    expq.push_back(v);
    tagq.push_back(t);
  endtask

  // Expand one instruction into the per-cycle outputs it must produce
  task automatic plan();
    vec_t v;
    logic [15:0] ir, a;
    logic [3:0] op, ra, rb, rc;
    logic [7:0] k;
    if (m_halt) begin
      v = base(m_pc);
      v.halted = 1'b1;
      push(v, '0, '0, 1'b0);
      return;
    end
    a = m_pc; ir = rom[a];
    op = ir[15:12]; ra = ir[11:8]; rb = ir[7:4]; rc = ir[3:0]; k = ir[7:0];
    v = base(a); v.i_rd = 1'b1;
    push(v, ir, a, 1'b0);
    m_pc = a + 16'd1;
    v = base(m_pc);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: push(v, ir, a, 1'b0);
      4'hF: begin push(v, ir, a, 1'b0); m_halt = 1'b1; end
      default: push(v, ir, a, 1'b1);
    endcase
    case (op)
      4'h0: begin
        v.d_addr = k; v.d_rd = 1'b1; v.rf_s = 1'b1; v.w_addr = ra; v.w_wr = 1'b1;
        push(v, ir, a, 1'b1);
      end
      4'h1: begin
        v.d_addr = k; v.d_wr = 1'b1; v.p_addr = ra; v.p_rd = 1'b1;
        push(v, ir, a, 1'b1);
      end
      4'h2, 4'h4: begin
        v.p_addr = rb; v.q_addr = rc; v.p_rd = 1'b1; v.q_rd = 1'b1;
        v.alu_s0 = (op == 4'h4); v.w_addr = ra; v.w_wr = 1'b1;
        push(v, ir, a, 1'b1);
      end
      4'h3, 4'h6: begin
        v.val_cons = k; v.rf_cons = 1'b1; v.rf_ext = (op == 4'h6);
        v.w_addr = ra; v.w_wr = 1'b1;
        push(v, ir, a, 1'b1);
      end
      4'h5: begin
        v.p_addr = ra; v.p_rd = 1'b1;
        if (m_rf[ra] == 16'h0000) begin
          push(v, ir, a, 1'b0);
          push(base(m_pc), ir, a, 1'b1);
        end else begin
          push(v, ir, a, 1'b0);
        end
      end
      default: ;
    endcase
  endtask

  task automatic commit(input tag_t t);
    logic [3:0] op, ra, rb, rc;
    logic [7:0] k;
    op = t.ir[15:12]; ra = t.ir[11:8]; rb = t.ir[7:4]; rc = t.ir[3:0]; k = t.ir[7:0];
    case (op)
      4'h0: m_rf[ra] = m_dm[k];
      4'h1: m_dm[k]  = m_rf[ra];
      4'h2: m_rf[ra] = m_rf[rb] + m_rf[rc];
      4'h3: m_rf[ra] = 16'(k);
      4'h4: m_rf[ra] = m_rf[rb] - m_rf[rc];
      4'h5: m_pc     = 16'(int'(t.addr) + int'($signed(k)));
      4'h6: m_rf[ra] = 16'(-int'(k));
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    vec_t e, act;
    tag_t t;
    if (!m_init) begin
      m_rf = env_rf;
      m_dm = env_dm;
      m_init = 1'b1;
    end
    act = '0;
    act.i_addr = I_addr;  act.i_rd = I_rd;      act.d_addr = D_addr;
    act.d_rd = D_rd;      act.d_wr = D_wr;      act.rf_s = RF_s;
    act.w_addr = RF_W_addr; act.p_addr = RF_Rp_addr; act.q_addr = RF_Rq_addr;
    act.w_wr = RF_W_wr;   act.p_rd = RF_Rp_rd;  act.q_rd = RF_Rq_rd;
    act.alu_s0 = alu_s0;  act.val_cons = Val_cons; act.rf_cons = RF_cons;
    act.rf_ext = RF_ext;  act.halted = halted;
    if (rst) begin
      expq.delete();
      tagq.delete();
      m_pc = '0;
      m_halt = 1'b0;
      check("reset outputs", {9'd0, act}, 64'd0);
      push('0, '0, '0, 1'b0);
    end else begin
      if (expq.size() == 0) plan();
      e = expq.pop_front();
      t = tagq.pop_front();
      check("cycle outputs", {9'd0, act}, {9'd0, e});
      if (RF_W_wr) wr_pulses++;
      if (t.last) commit(t);
    end
  end

  task automatic rst_on();
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic rst_off();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    repeat (c) @(posedge clk);
    @(negedge clk); #1;
  endtask

  initial begin : main
    int w0, bad;
    logic [3:0] op;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h3000;

    // LDC R1,5 ; LDN R2,3 ; ADD R3,R1,R2
    rom[0] = 16'h3105; rom[1] = 16'h6203; rom[2] = 16'h2312;
    rst_off();
    w0 = wr_pulses;
    repeat (10) @(posedge clk); #1;
    check("add R3", 64'(env_rf[3]), 64'h0002);
    check("model add R3", 64'(m_rf[3]), 64'h0002);
    check("write pulses", 64'(wr_pulses - w0), 64'd3);

    // LDC R1,2 ; LDC R2,5 ; SUB R3,R1,R2
    rst_on();
    rom[0] = 16'h3102; rom[1] = 16'h3205; rom[2] = 16'h4312;
    rst_off();
    at_cycle(9);
    check("sub alu state", 64'({alu_s0, RF_W_wr, RF_W_addr}), 64'h3_3);
    @(posedge clk); #1;
    check("sub R3", 64'(env_rf[3]), 64'hFFFD);

    // LOAD R4,0x10 ; STORE R4,0x20
    rst_on();
    rom[0] = 16'h0410; rom[1] = 16'h1420; rom[2] = 16'h3000;
    rst_off();
    repeat (7) @(posedge clk); #1;
    check("load R4", 64'(env_rf[4]), 64'hBEEF);
    check("store dm20", 64'(env_dm[8'h20]), 64'hBEEF);

    // JMPZ R5,-2 at address 4, taken (R5 = 0)
    rst_on();
    for (int i = 0; i < 4; i++) rom[i] = 16'h3000;
    rom[4] = 16'h55FE;
    rst_off();
    at_cycle(17);
    check("jmpz taken addr", 64'(I_addr), 64'h0002);
    check("jmpz taken fetch", 64'(I_rd), 64'd1);

    // same, not taken (R5 = 1)
    rst_on();
    rom[0] = 16'h3501;
    rst_off();
    at_cycle(16);
    check("jmpz fall addr", 64'(I_addr), 64'h0005);
    check("jmpz fall fetch", 64'(I_rd), 64'd1);

    // HALT, then reset out of it
    rst_on();
    rom[0] = 16'hF000;
    rst_off();
    at_cycle(3);
    check("halt entry", 64'({halted, I_rd}), 64'h2);
    at_cycle(4);
    check("halt held", 64'({halted, I_rd}), 64'h2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    check("halt cleared by rst", 64'(halted), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("init after halt", 64'({halted, I_addr}), 64'h0);
    @(negedge clk); #1;
    check("first fetch", 64'({I_rd, I_addr}), 64'h1_0000);

    // rst during the ALU state of ADD R6,R1,R1
    rst_on();
    rom[0] = 16'h3107; rom[1] = 16'h2611;
    rst_off();
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("aborted write", 64'(RF_W_wr), 64'd0);
    @(posedge clk); #1;
    check("R6 untouched", 64'(env_rf[6]), 64'h0000);

    // randomized programs with occasional resets
    rst_on();
    for (int i = 0; i < 65536; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h3;
      rom[i] = {op, 12'($urandom)};
    end
    rst_off();
    repeat (4000) begin
      @(posedge clk);
      #1 rst = ($urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 16; i++) check("final reg", 64'(env_rf[i]), 64'(m_rf[i]));
    bad = 0;
    for (int i = 0; i < 256; i++) if (env_dm[i] !== m_dm[i]) bad++;
    check("final dmem diffs", 64'(bad), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
